// File: rtl/led_bcm_driver.sv
// led_bcm_driver
// HUB75 panel scan engine using binary-coded modulation (BCM).
// For every row address it shifts one bit plane of all columns into the
// panel and then latches it. The plane stays lit for LSB_CYCLES*2^plane
// clocks. The next plane is shifted in while the current one is displayed.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   pix_x        column currently being fetched from the painter
//   pix_y        row address being fetched (upper half {0,pix_y}, lower {1,pix_y})
//   pix_plane    bit plane being fetched
//   pix_rgb0     upper-half pixel {B,G,R}, combinational answer to pix_x/pix_y
//   pix_rgb1     lower-half pixel {B,G,R}
//   led_rgb0     upper-half shift data {B,G,R}, registered
//   led_rgb1     lower-half shift data {B,G,R}, registered
//   led_addr     panel row select, registered
//   blank_ddr    output-enable-inverse phases {second half, first half}
//   latch_ddr    latch phases
//   sclk_ddr     shift-clock phases
//   frame_start  one-clock pulse on the first column of row 0, plane 0
module led_bcm_driver #(
   parameter int ADDR_BITS   = 5,
   parameter int COL_BITS    = 6,
   parameter int COLOR_BITS  = 8,
   parameter int LSB_CYCLES  = 64,
   parameter int START_DELAY = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic [COL_BITS-1:0]           pix_x,
   output logic [ADDR_BITS-1:0]          pix_y,
   output logic [$clog2(COLOR_BITS)-1:0] pix_plane,
   input  logic [3*COLOR_BITS-1:0]       pix_rgb0,
   input  logic [3*COLOR_BITS-1:0]       pix_rgb1,
   output logic [2:0]                    led_rgb0,
   output logic [2:0]                    led_rgb1,
   output logic [ADDR_BITS-1:0]          led_addr,
   output logic [1:0]                    blank_ddr,
   output logic [1:0]                    latch_ddr,
   output logic [1:0]                    sclk_ddr,
   output logic                          frame_start
);

   localparam int PLANE_W = $clog2(COLOR_BITS);
   localparam int TIMER_W = $clog2(LSB_CYCLES) + COLOR_BITS;
   localparam int DELAY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

   typedef enum logic [5:0] {
      S_START   = 6'b000001,
      S_SHIFT   = 6'b000010,
      S_WAIT    = 6'b000100,
      S_BLANK   = 6'b001000,
      S_LATCH   = 6'b010000,
      S_UNBLANK = 6'b100000
   } state_t;

   state_t               state;
   logic [COL_BITS-1:0]  col;
   logic [ADDR_BITS-1:0] row;
   logic [PLANE_W-1:0]   plane;
   logic [TIMER_W-1:0]   on_timer;
   logic [DELAY_W-1:0]   delay;
   logic                 lit;

   logic [COLOR_BITS-1:0] r0, g0, b0, r1, g1, b1;
   logic [TIMER_W-1:0]    on_time;

   // The fetch port simply mirrors the scan position; the painter answers
   // combinationally within the same cycle.
   assign pix_x     = col;
   assign pix_y     = row;
   assign pix_plane = plane;

   assign r0 = pix_rgb0[COLOR_BITS-1:0];
   assign g0 = pix_rgb0[2*COLOR_BITS-1:COLOR_BITS];
   assign b0 = pix_rgb0[3*COLOR_BITS-1:2*COLOR_BITS];
   assign r1 = pix_rgb1[COLOR_BITS-1:0];
   assign g1 = pix_rgb1[2*COLOR_BITS-1:COLOR_BITS];
   assign b1 = pix_rgb1[3*COLOR_BITS-1:2*COLOR_BITS];

   // Binary weighting of the display time: each plane stays lit twice as
   // long as the one below it.
   assign on_time = TIMER_W'(LSB_CYCLES) << plane;

   // Scan sequencer. The on-time timer keeps running through the shift of
   // the next plane, so display and shifting overlap. S_WAIT only holds the
   // sequencer when shifting finished before the on-time expired. The timer
   // is loaded with the full on-time, which together with the blank/latch
   // steps gives a lit window of on-time + 2 clocks. When shifting takes
   // longer, the window becomes shift length + 2.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_START;
         col         <= '0;
         row         <= '0;
         plane       <= '0;
         on_timer    <= '0;
         lit         <= 1'b0;
         delay       <= DELAY_W'(START_DELAY - 1);
         led_rgb0    <= 3'b000;
         led_rgb1    <= 3'b000;
         led_addr    <= '0;
         blank_ddr   <= 2'b11;
         latch_ddr   <= 2'b00;
         sclk_ddr    <= 2'b00;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (lit && on_timer != '0) begin
            on_timer <= on_timer - 1'b1;
         end
         case (state)
            S_START: begin
               if (delay == '0) begin
                  state <= S_SHIFT;
               end else begin
                  delay <= delay - 1'b1;
               end
            end
            S_SHIFT: begin
               led_rgb0    <= {b0[plane], g0[plane], r0[plane]};
               led_rgb1    <= {b1[plane], g1[plane], r1[plane]};
               sclk_ddr    <= 2'b10;
               frame_start <= (col == '0) && (row == '0) && (plane == '0);
               col         <= col + 1'b1;
               if (col == '1) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               sclk_ddr <= 2'b00;
               if (on_timer == '0) begin
                  state <= S_BLANK;
               end
            end
            S_BLANK: begin
               blank_ddr <= 2'b11;
               state     <= S_LATCH;
            end
            S_LATCH: begin
               latch_ddr <= 2'b11;
               led_addr  <= row;
               state     <= S_UNBLANK;
            end
            S_UNBLANK: begin
               latch_ddr <= 2'b00;
               blank_ddr <= 2'b00;
               lit       <= 1'b1;
               on_timer  <= on_time;
               col       <= '0;
               if (plane == PLANE_W'(COLOR_BITS - 1)) begin
                  plane <= '0;
                  row   <= row + 1'b1;
               end else begin
                  plane <= plane + 1'b1;
               end
               state <= S_SHIFT;
            end
            default: begin
               state <= S_START;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_bcm_driver.sv
// tb_led_bcm_driver
// Self-checking bench for led_bcm_driver. A random image is served on the
// pixel fetch port; a monitor walks the output protocol one clock at a time
// and compares it to a plane-period schedule computed from the scan rules:
// period k shows row (k / C) mod R and plane k mod C, shifts COLS columns,
// latches once, and stays lit for max(LSB*2^plane, COLS) + 2 clocks.
module tb_led_bcm_driver;

   localparam int A    = 1;
   localparam int CB   = 2;
   localparam int C    = 8;
   localparam int LSB  = 2;
   localparam int SD   = 1;
   localparam int R    = 1 << A;
   localparam int COLS = 1 << CB;
   localparam int PW   = $clog2(C);

   logic            clk;
   logic            reset;
   logic [CB-1:0]   pix_x;
   logic [A-1:0]    pix_y;
   logic [PW-1:0]   pix_plane;
   logic [3*C-1:0]  pix_rgb0;
   logic [3*C-1:0]  pix_rgb1;
   logic [2:0]      led_rgb0;
   logic [2:0]      led_rgb1;
   logic [A-1:0]    led_addr;
   logic [1:0]      blank_ddr;
   logic [1:0]      latch_ddr;
   logic [1:0]      sclk_ddr;
   logic            frame_start;

   logic [3*C-1:0]  img0 [R][COLS];
   logic [3*C-1:0]  img1 [R][COLS];

   int assertCount = 0;
   int failCount   = 0;

   // Monitor bookkeeping, all owned by the main initial block.
   int cycles;
   int shiftK;
   int shiftCnt;
   int latchK;
   int litK;
   int blankRun;
   bit latchPrev;

   led_bcm_driver #(
      .ADDR_BITS   (A),
      .COL_BITS    (CB),
      .COLOR_BITS  (C),
      .LSB_CYCLES  (LSB),
      .START_DELAY (SD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_plane   (pix_plane),
      .pix_rgb0    (pix_rgb0),
      .pix_rgb1    (pix_rgb1),
      .led_rgb0    (led_rgb0),
      .led_rgb1    (led_rgb1),
      .led_addr    (led_addr),
      .blank_ddr   (blank_ddr),
      .latch_ddr   (latch_ddr),
      .sclk_ddr    (sclk_ddr),
      .frame_start (frame_start)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // The painter model answers the fetch port combinationally.
   always_comb begin
      pix_rgb0 = img0[pix_y][pix_x];
      pix_rgb1 = img1[pix_y][pix_x];
   end

   // Counts one comparison and reports it when it does not hold.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at cycle %0d",
                  tag, observed, expected, cycles);
      end
   endtask

   // Pulls bit p of each colour channel out of a packed {B,G,R} pixel.
   function automatic logic [2:0] planeBits(input logic [3*C-1:0] pix, input int p);
      int unsigned mask;
      int unsigned r, g, b;
      mask = (1 << C) - 1;
      r = (int'(pix) >> p) & 1;
      g = ((int'(pix) >> C) & mask) >> p & 1;
      b = ((int'(pix) >> (2 * C)) & mask) >> p & 1;
      return {b[0], g[0], r[0]};
   endfunction

   // Length of the blank=00 window for a plane.
   function automatic int litLen(input int p);
      int onTime;
      onTime = LSB << p;
      return ((onTime > COLS) ? onTime : COLS) + 2;
   endfunction

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_rgb0"},  32'(led_rgb0),    32'h0);
      checkOutput({tag, "_rgb1"},  32'(led_rgb1),    32'h0);
      checkOutput({tag, "_addr"},  32'(led_addr),    32'h0);
      checkOutput({tag, "_blank"}, 32'(blank_ddr),   32'h3);
      checkOutput({tag, "_latch"}, 32'(latch_ddr),   32'h0);
      checkOutput({tag, "_sclk"},  32'(sclk_ddr),    32'h0);
      checkOutput({tag, "_frame"}, 32'(frame_start), 32'h0);
   endtask

   task automatic resetMonitor();
      shiftK    = 0;
      shiftCnt  = 0;
      latchK    = 0;
      litK      = 0;
      blankRun  = 0;
      latchPrev = 1'b0;
   endtask

   // Advances one clock, samples on the falling edge and checks the shift,
   // latch and blank behaviour against the plane-period schedule.
   task automatic monitorCycle();
      int row, plane;
      @(negedge clk);
      cycles++;
      if (sclk_ddr == 2'b10) begin
         row   = (shiftK / C) % R;
         plane = shiftK % C;
         checkOutput("shift_rgb0", 32'(led_rgb0), 32'(planeBits(img0[row][shiftCnt], plane)));
         checkOutput("shift_rgb1", 32'(led_rgb1), 32'(planeBits(img1[row][shiftCnt], plane)));
         checkOutput("frame_start", 32'(frame_start),
                     32'((shiftCnt == 0) && (shiftK % (R * C) == 0)));
         checkOutput("shift_plane_order", 32'(shiftK), 32'(latchK));
         if (shiftCnt < COLS - 1) begin
            checkOutput("pix_x", 32'(pix_x), 32'(shiftCnt + 1));
         end
         shiftCnt++;
         if (shiftCnt == COLS) begin
            shiftCnt = 0;
            shiftK++;
         end
      end else begin
         checkOutput("sclk_idle", 32'(sclk_ddr), 32'h0);
         checkOutput("frame_idle", 32'(frame_start), 32'h0);
      end

      if (latchPrev) begin
         checkOutput("latch_width", 32'(latch_ddr), 32'h0);
      end
      if (latch_ddr == 2'b11) begin
         checkOutput("latch_in_blank", 32'(blank_ddr), 32'h3);
         checkOutput("latch_after_shift", 32'(shiftK), 32'(latchK + 1));
         checkOutput("led_addr", 32'(led_addr), 32'((latchK / C) % R));
         latchK++;
         latchPrev = 1'b1;
      end else begin
         latchPrev = 1'b0;
      end

      if (latchK == 0) begin
         checkOutput("blank_prelatch", 32'(blank_ddr), 32'h3);
      end
      if (blank_ddr == 2'b00) begin
         blankRun++;
      end else begin
         if (blankRun > 0) begin
            checkOutput("lit_length", 32'(blankRun), 32'(litLen(litK % C)));
            litK++;
            blankRun = 0;
         end
      end
   endtask

   // Releases reset and checks the first shift begins two clocks later.
   task automatic applyStimulus(input int periods, input string tag);
      int budget;
      reset = 1'b0;
      resetMonitor();
      monitorCycle();
      checkOutput({tag, "_start_idle"}, 32'(sclk_ddr), 32'h0);
      monitorCycle();
      checkOutput({tag, "_start_sclk"}, 32'(sclk_ddr), 32'h2);
      checkOutput({tag, "_start_frame"}, 32'(frame_start), 32'h1);
      budget = 0;
      while (latchK < periods && budget < 20000) begin
         monitorCycle();
         budget++;
      end
      checkOutput({tag, "_periods_done"}, 32'(latchK), 32'(periods));
   endtask

   initial begin
      int n;
      cycles = 0;
      resetMonitor();
      for (int y = 0; y < R; y++) begin
         for (int x = 0; x < COLS; x++) begin
            img0[y][x] = (3 * C)'($urandom);
            img1[y][x] = (3 * C)'($urandom);
         end
      end
      img0[0][0] = 24'hA5_00_FF;
      img1[R-1][COLS-1] = 24'h00_00_00;
      img0[R-1][1] = 24'hFF_FF_FF;

      reset = 1'b1;
      repeat (5) @(negedge clk);
      checkResetValues("reset");

      // Three full frames: led_addr, lit windows and frame_start cadence.
      applyStimulus(3 * R * C, "run");

      // Abort in the middle of a shift, at column 2.
      n = 0;
      while (!(pix_x == 2 && sclk_ddr == 2'b10) && n < 500) begin
         monitorCycle();
         n++;
      end
      checkOutput("midreset_reached", 32'(n < 500), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      cycles++;
      checkResetValues("midreset");

      applyStimulus(R * C, "restart");

      $display("[TB] End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
